// File: rtl/sort_pkg.sv
// Shared types and width helpers for the sorter output drain.
// Element and lane-vector typedefs are sized for the default configuration;
// parameterized modules size their own buses from N/M.
package sort_pkg;

    localparam int SORT_N = 4;
    localparam int SORT_M = 4;
    localparam int SORT_D = 2;

    typedef logic [SORT_N-1:0] elem_t;
    typedef elem_t [SORT_M-1:0] lane_vec_t;

    // Width of a counter that must hold 0..d inclusive.
    function automatic int cnt_width(input int d);
        return $clog2(d + 1);
    endfunction

    // Width of an index over 0..m-1 (never narrower than one bit).
    function automatic int idx_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/shift_reg.sv
// ShiftReg: fixed-depth delay line.
// Ports:
//   Clk  - rising-edge clock
//   Clr  - synchronous clear of all stages
//   D    - input word
//   Q    - input delayed by DEPTH cycles
module ShiftReg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= D;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign Q = stage[DEPTH-1];

endmodule

// File: rtl/sort_vec_fifo.sv
// sort_vec_fifo: D-entry FIFO of whole vectors, first-word fall-through.
// A push while full is accepted only if a pop happens in the same cycle
// (the pop frees the slot first); otherwise the push is ignored and the
// caller is expected to flag the loss.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (pointers/count)
//   push        - write request
//   wr_data     - vector to write
//   pop         - remove head (ignored when empty)
//   rd_data     - head vector, valid while !empty
//   full, empty - occupancy flags
module sort_vec_fifo
    import sort_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int CW = cnt_width(D);
    localparam int PW = idx_width(D);

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_pop, do_push;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(D));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sort_output_drain.sv
// sort_output_drain: deskews the sorter's lane-staggered results into whole
// vectors, buffers them, and serializes each vector onto a one-element
// valid/ready stream. Vectors arriving while the buffer is full (and not
// draining a vector that same cycle) are dropped and Overflow latches.
// Ports:
//   Clk, Reset - clock, synchronous active-high reset
//   InValid    - lane-0 strobe of a sorted vector
//   InData     - sorted lanes; lane j valid j cycles after InValid
//   OutValid   - element valid
//   OutReady   - downstream accepts element
//   OutData    - current element (0 when idle)
//   OutLast    - current element ends its vector
//   Overflow   - sticky vector-drop flag
module sort_output_drain
    import sort_pkg::*;
#(
    parameter int N       = SORT_N,
    parameter int M       = SORT_M,
    parameter int D       = SORT_D,
    parameter int DESCEND = 0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         InValid,
    input  logic [N-1:0] InData [M],
    output logic         OutValid,
    input  logic         OutReady,
    output logic [N-1:0] OutData,
    output logic         OutLast,
    output logic         Overflow
);

    localparam int IW = idx_width(M);

    logic [M-2:0]   vld_pipe;
    logic           strobe;
    logic [N-1:0]   aligned [M];
    logic [M*N-1:0] wr_vec, head_vec;
    logic           full, empty;
    logic           beat, pop, at_last;
    logic [IW-1:0]  idx, lane_sel;
    logic           overflow_q;

    // Valid is delayed to line up with the last (undelayed) lane.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= InValid;
            for (int i = 1; i < M - 1; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign strobe = vld_pipe[M-2];

    for (genvar j = 0; j < M - 1; j++) begin : g_deskew
        ShiftReg #(.WIDTH(N), .DEPTH(M - 1 - j)) u_dly (
            .Clk (Clk),
            .Clr (1'b0),
            .D   (InData[j]),
            .Q   (aligned[j])
        );
    end
    assign aligned[M-1] = InData[M-1];

    always_comb begin
        wr_vec = '0;
        for (int j = 0; j < M; j++) wr_vec[j*N +: N] = aligned[j];
    end

    sort_vec_fifo #(.W(M * N), .D(D)) u_fifo (
        .clk     (Clk),
        .reset   (Reset),
        .push    (strobe),
        .wr_data (wr_vec),
        .pop     (pop),
        .rd_data (head_vec),
        .full    (full),
        .empty   (empty)
    );

    assign OutValid = ~empty;
    assign at_last  = (idx == IW'(M - 1));
    assign beat     = OutValid & OutReady;
    assign pop      = beat & at_last;
    assign OutLast  = OutValid & at_last;
    assign lane_sel = (DESCEND != 0) ? IW'(M - 1) - idx : idx;
    assign Overflow = overflow_q;

    always_comb begin
        OutData = '0;
        if (OutValid) begin
            for (int j = 0; j < M; j++) begin
                if (lane_sel == IW'(j)) OutData = head_vec[j*N +: N];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (beat) idx <= at_last ? '0 : idx + 1'b1;
            // Drop only when no slot frees up this cycle.
            if (strobe & full & ~pop) overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sort_output_drain.sv
module tb_sort_output_drain;

    localparam int N  = 4;
    localparam int M  = 4;
    localparam int D  = 2;
    localparam int NC = 32;

    logic         Clk = 1'b0;
    logic         Reset, InValid, OutReady;
    logic [N-1:0] InData [M];
    logic         ov0, ol0, of0, ov1, ol1, of1;
    logic [N-1:0] od0, od1;

    always #5 Clk = ~Clk;

    sort_output_drain #(.N(N), .M(M), .D(D), .DESCEND(0)) dut_asc (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InData(InData),
        .OutValid(ov0), .OutReady(OutReady), .OutData(od0),
        .OutLast(ol0), .Overflow(of0)
    );

    sort_output_drain #(.N(N), .M(M), .D(D), .DESCEND(1)) dut_desc (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InData(InData),
        .OutValid(ov1), .OutReady(OutReady), .OutData(od1),
        .OutLast(ol1), .Overflow(of1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // scenario description
    int          nvec;
    int          vstart [3];
    logic [15:0] vdata  [3];
    int          rst_cyc, lo_a, lo_b;
    logic        exp_v [NC];
    logic        exp_l [NC];
    logic        exp_o [NC];
    logic [3:0]  exp_d [NC];
    logic [3:0]  exp_dd [NC];

    task automatic clear_case();
        nvec    = 0;
        rst_cyc = -1;
        lo_a    = -1;
        lo_b    = -1;
        for (int c = 0; c < NC; c++) begin
            exp_v[c] = 0; exp_l[c] = 0; exp_o[c] = 0;
            exp_d[c] = 0; exp_dd[c] = 0;
        end
    endtask

    task automatic add_vec(input int s, input logic [15:0] v);
        vstart[nvec] = s;
        vdata[nvec]  = v;
        nvec++;
    endtask

    // expected four-beat drain of v starting at cycle c0 with no stalls
    task automatic put_vec(input int c0, input logic [15:0] v);
        for (int k = 0; k < 4; k++) begin
            exp_v[c0+k]  = 1;
            exp_d[c0+k]  = v[k*4 +: 4];
            exp_dd[c0+k] = v[(3-k)*4 +: 4];
        end
        exp_l[c0+3] = 1;
    endtask

    task automatic run_case(input string name, input bit chk_desc);
        for (int c = 0; c < NC; c++) begin
            @(negedge Clk);
            Reset    = (c < 2) || (c == rst_cyc);
            OutReady = !(c >= lo_a && c <= lo_b);
            InValid  = 0;
            for (int j = 0; j < M; j++) InData[j] = '0;
            for (int v = 0; v < nvec; v++) begin
                if (vstart[v] == c) InValid = 1;
                for (int j = 0; j < M; j++)
                    if (vstart[v] + j == c) InData[j] = vdata[v][j*4 +: 4];
            end
            #1;
            if (c >= 2) begin
                chk($sformatf("%s c%0d valid", name, c), 32'(ov0), 32'(exp_v[c]));
                chk($sformatf("%s c%0d data", name, c), 32'(od0), 32'(exp_d[c]));
                chk($sformatf("%s c%0d last", name, c), 32'(ol0), 32'(exp_l[c]));
                chk($sformatf("%s c%0d ovf", name, c), 32'(of0), 32'(exp_o[c]));
                if (chk_desc) begin
                    chk($sformatf("%s c%0d dvalid", name, c), 32'(ov1), 32'(exp_v[c]));
                    chk($sformatf("%s c%0d ddata", name, c), 32'(od1), 32'(exp_dd[c]));
                    chk($sformatf("%s c%0d dlast", name, c), 32'(ol1), 32'(exp_l[c]));
                end
            end
        end
    endtask

    localparam logic [15:0] VA = {4'd9, 4'd7, 4'd3, 4'd1};
    localparam logic [15:0] VB = {4'd8, 4'd6, 4'd4, 4'd2};
    localparam logic [15:0] VC = {4'd15, 4'd11, 4'd10, 4'd5};

    initial begin
        Reset = 1; InValid = 0; OutReady = 1;
        for (int j = 0; j < M; j++) InData[j] = '0;

        // single vector, both orders
        clear_case();
        add_vec(10, VA);
        put_vec(14, VA);
        run_case("single", 1'b1);

        // A,B,C back-to-back: C dropped
        clear_case();
        add_vec(10, VA); add_vec(11, VB); add_vec(12, VC);
        put_vec(14, VA); put_vec(18, VB);
        for (int c = 16; c < NC; c++) exp_o[c] = 1;
        run_case("overflow", 1'b0);

        // C strobe meets A's last beat while full: accepted
        clear_case();
        add_vec(10, VA); add_vec(11, VB); add_vec(14, VC);
        put_vec(14, VA); put_vec(18, VB); put_vec(22, VC);
        run_case("popwrite", 1'b0);

        // backpressure on the first element
        clear_case();
        add_vec(10, VA);
        lo_a = 14; lo_b = 16;
        for (int c = 14; c < 17; c++) begin
            exp_v[c] = 1; exp_d[c] = 4'd1;
        end
        put_vec(17, VA);
        run_case("bkpr", 1'b0);

        // reset in cycle 15 abandons the drain
        clear_case();
        add_vec(10, VA);
        rst_cyc = 15;
        exp_v[14] = 1; exp_d[14] = 4'd1;
        exp_v[15] = 1; exp_d[15] = 4'd3;
        run_case("rstmid", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sort_output_drain.md
# sort_output_drain

Output-side companion to the systolic wide sorter. It accepts the sorter's M lane-skewed sorted results, deskews them into whole vectors, and buffers them in a small vector FIFO. It then serializes each vector onto a single-element valid/ready stream. The sorter has no backpressure, so this block absorbs rate mismatch and flags any loss.

## Interface
- `N`, default 4: element width in bits.
- `M`, default 4: lanes per sorted vector, M ≥ 2.
- `D`, default 2: FIFO depth in whole vectors, D ≥ 1.
- `DESCEND`, default 0: 0 emits lane 0 first (smallest first); 1 emits lane M-1 first.
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `InValid` in 1: lane-0 strobe of a sorted vector from the sorter.
- `InData[M-1:0]` in N each: unpacked sorted lanes; lane 0 holds the minimum.
- `OutValid` out 1: stream element valid.
- `OutReady` in 1: downstream accepts the element.
- `OutData` out N: current element.
- `OutLast` out 1: current element is the final one of its vector.
- `Overflow` out 1: sticky; a vector was dropped.

## Operation
- **Skew contract:** when InValid is high in cycle t, lane j of InData is valid in cycle t+j. InValid may assert every cycle.
- **Deskew:** lane j is delayed by M-1-j cycles; lane M-1 is not delayed. InValid is delayed by M-1 cycles. The result is an aligned strobe in cycle t+M-1 carrying the complete vector.
- **FIFO write:** the aligned strobe writes the vector if the FIFO is not full.
  - A pop in the same cycle frees a slot first, so the write is accepted.
  - Otherwise, with the FIFO full, the vector is dropped and Overflow is set.
- **FIFO pointers:** wrap from D-1 to 0. The count runs 0..D.
- **Serializer:** an element index runs 0..M-1 over the head vector. The emitted lane is the index when DESCEND=0 and M-1-index when DESCEND=1.
  - A beat is accepted when OutValid & OutReady.
  - Each accepted beat increments the index.
  - The beat at index M-1 pops the vector and resets the index to 0.
- **Outputs:**
  - OutValid = FIFO not empty.
  - OutLast = OutValid & (index == M-1).
  - OutData = 0 whenever OutValid = 0.
- **Handshake rules:** once OutValid is high, it is held until the beat is accepted. OutData and OutLast stay stable while OutValid & !OutReady.
- **Overflow:** cleared only by Reset.
- **Reset:** applies on the next edge and clears the deskew valid pipeline, FIFO pointers, count, index and Overflow.
  - Any partially drained vector is abandoned.
  - Any in-flight skewed vector is discarded.
  - Deskew data registers need not be cleared.

## Timing
- **Reset values:** OutValid=0, OutLast=0, OutData=0, Overflow=0.
- **Latency, FIFO empty, OutReady high:**
  - InValid in cycle t gives the aligned strobe in cycle t+M-1.
  - The first element appears in cycle t+M.
  - The last element, with OutLast, appears in cycle t+2M-1.
- **Throughput:** one element per cycle. There are no bubbles between consecutive buffered vectors.
- **Sustained rate:** the sorter may deliver one vector per cycle, but the drain side takes M cycles per vector. Sustained input faster than one vector per M cycles therefore overflows once D vectors are held.
- **Overflow timing:** Overflow rises in the cycle after the dropped strobe.

## Structure
- **Package `sort_pkg`:** holds the element typedef (logic [N-1:0]), the lane-vector typedef, and the FIFO count/index width functions ($clog2(D+1), $clog2(M)).
- **Deskew:** reuses the existing `ShiftReg`, one instance per lane j<M-1, with depth M-1-j. Its Clr input is tied low.
- **Sub-module `sort_vec_fifo`:** a D-entry, M×N-bit FIFO with first-word fall-through, full/empty flags, and the pop-before-write rule when full.
- **Top level:** the valid delay pipeline, the serializer index and output gating stay in the top module.

## Test plan
All scenarios use N=4, M=4, D=2.
- **Single vector:** InValid in cycle 10 with lanes {1,3,7,9} skewed, OutReady high -> OutData 1,3,7,9 in cycles 14–17, OutLast only in cycle 17, Overflow=0.
- **Descending order:** the same stimulus with DESCEND=1 -> 9,7,3,1 in cycles 14–17.
- **Overflow:** InValid in cycles 10, 11, 12 with vectors A, B, C -> A then B drain with no gap in cycles 14–21, C is dropped, Overflow=1 from cycle 16 and stays high.
- **Pop-and-write when full:** A at 10, B at 11, C at 14 -> C's strobe coincides with A's last beat in cycle 17 and C is accepted; output is A, B, C over cycles 14–25 with no bubble, Overflow=0.
- **Backpressure:** single vector as above with OutReady low in cycles 14–16 -> OutValid=1 and OutData=1 held in cycles 14–16, then 1,3,7,9 in cycles 17–20.
- **Reset mid-drain:** Reset high in cycle 15 of the single-vector case -> from cycle 16 OutValid=0, OutData=0, Overflow=0, and no further beats.
